layer_output_stage: RTL and testbench

- Downstream stage of the fully-connected layer accelerator.
- Captures the accelerator's parallel output vector (OUTPUT_NEURON_COUNT x 16-bit) with a valid/ready handshake.
- Optionally applies ReLU to each element, then streams the elements out one per beat on a valid/ready interface.
- Tracks the running argmax and reports it at the end of each vector, for the classification output of the last layer.

---
 rtl/layer_output_stage_if.sv | 31 +++
 rtl/layer_output_stage.sv | 127 ++++++++++++
 tb/tb_layer_output_stage.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/layer_output_stage_if.sv
// rtl/layer_output_stage_if.sv - vector capture, element stream and argmax signals of the layer output stage
// master: upstream/downstream environment side; slave: the output stage itself.
interface layer_output_stage_if #(
   parameter int N      = 15,
   parameter int DATA_W = 16,
   parameter int IDX_W  = $clog2(N)
);
   logic              vec_valid;
   logic              vec_ready;
   logic [DATA_W-1:0] vec_data [0:N-1];
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic [IDX_W-1:0]  m_index;
   logic              m_last;
   logic              argmax_valid;
   logic [IDX_W-1:0]  argmax_idx;
   logic [DATA_W-1:0] argmax_val;

   modport master (
      output vec_valid, vec_data, m_ready,
      input  vec_ready, m_valid, m_data, m_index, m_last,
             argmax_valid, argmax_idx, argmax_val
   );

   modport slave (
      input  vec_valid, vec_data, m_ready,
      output vec_ready, m_valid, m_data, m_index, m_last,
             argmax_valid, argmax_idx, argmax_val
   );
endinterface

// File: rtl/layer_output_stage.sv
// rtl/layer_output_stage.sv - captures an output vector, streams it one element per beat, reports argmax
// Optional ReLU at capture when LAYER_OUTPUT_RELU_EN is defined.
module layer_output_stage #(
   parameter int OUTPUT_NEURON_COUNT = 15,
   parameter int DATA_W              = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   layer_output_stage_if.slave     bus
);
   localparam int IDX_W = $clog2(OUTPUT_NEURON_COUNT);
   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_STREAM = 1'b1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_NEURON_COUNT - 1);

   logic [0:0]        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] elem_q [0:OUTPUT_NEURON_COUNT-1];
   logic [DATA_W-1:0] elem_d [0:OUTPUT_NEURON_COUNT-1];
   logic [DATA_W-1:0] run_val_q, run_val_d;
   logic [IDX_W-1:0]  run_idx_q, run_idx_d;
   logic              argmax_valid_q, argmax_valid_d;
   logic [IDX_W-1:0]  argmax_idx_q, argmax_idx_d;
   logic [DATA_W-1:0] argmax_val_q, argmax_val_d;

   logic              capture;
   logic              beat_acc;
   logic              last_beat;
   logic              take;
   logic [DATA_W-1:0] cur;
   logic [DATA_W-1:0] new_val;
   logic [IDX_W-1:0]  new_idx;

   function automatic logic [DATA_W-1:0] activate(input logic [DATA_W-1:0] x);
`ifdef LAYER_OUTPUT_RELU_EN
      activate = x[DATA_W-1] ? '0 : x;
`else
      activate = x;
`endif
   endfunction

   assign capture   = (state_q == ST_IDLE) && bus.vec_valid;
   assign beat_acc  = (state_q == ST_STREAM) && bus.m_ready;
   assign last_beat = beat_acc && (idx_q == LAST_IDX);
   assign cur       = elem_q[idx_q];

   // Beat 0 seeds the running max; later beats need a strict win so ties keep the lowest index.
   assign take    = (idx_q == '0) || ($signed(cur) > $signed(run_val_q));
   assign new_val = take ? cur : run_val_q;
   assign new_idx = take ? idx_q : run_idx_q;

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      elem_d         = elem_q;
      run_val_d      = run_val_q;
      run_idx_d      = run_idx_q;
      argmax_valid_d = 1'b0;
      argmax_idx_d   = argmax_idx_q;
      argmax_val_d   = argmax_val_q;

      case (state_q)
         ST_IDLE: begin
            if (capture) begin
               for (int i = 0; i < OUTPUT_NEURON_COUNT; i++) begin
                  elem_d[i] = activate(bus.vec_data[i]);
               end
               idx_d   = '0;
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (beat_acc) begin
               run_val_d = new_val;
               run_idx_d = new_idx;
               if (last_beat) begin
                  idx_d          = '0;
                  state_d        = ST_IDLE;
                  argmax_valid_d = 1'b1;
                  argmax_idx_d   = new_idx;
                  argmax_val_d   = new_val;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         idx_q          <= '0;
         for (int i = 0; i < OUTPUT_NEURON_COUNT; i++) begin
            elem_q[i] <= '0;
         end
         run_val_q      <= '0;
         run_idx_q      <= '0;
         argmax_valid_q <= 1'b0;
         argmax_idx_q   <= '0;
         argmax_val_q   <= '0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         elem_q         <= elem_d;
         run_val_q      <= run_val_d;
         run_idx_q      <= run_idx_d;
         argmax_valid_q <= argmax_valid_d;
         argmax_idx_q   <= argmax_idx_d;
         argmax_val_q   <= argmax_val_d;
      end
   end

   // Stream outputs are forced to zero outside STREAM so IDLE shows clean reset-like values.
   assign bus.vec_ready    = (state_q == ST_IDLE);
   assign bus.m_valid      = (state_q == ST_STREAM);
   assign bus.m_data       = (state_q == ST_STREAM) ? cur : '0;
   assign bus.m_index      = (state_q == ST_STREAM) ? idx_q : '0;
   assign bus.m_last       = (state_q == ST_STREAM) && (idx_q == LAST_IDX);
   assign bus.argmax_valid = argmax_valid_q;
   assign bus.argmax_idx   = argmax_idx_q;
   assign bus.argmax_val   = argmax_val_q;
endmodule

// File: tb/tb_layer_output_stage.sv
// tb/tb_layer_output_stage.sv - directed vectors for layer_output_stage
module tb_layer_output_stage;
   localparam int N = 15;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   logic [15:0] vec_in   [0:N-1];
   logic [15:0] vec_hold [0:N-1];
   logic [15:0] exp_out  [0:N-1];

   layer_output_stage_if #(.N(N), .DATA_W(16)) bus ();

   layer_output_stage #(.OUTPUT_NEURON_COUNT(N), .DATA_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired got running exp finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
      end
   endtask

   // Entered and left at a falling edge; returns on the argmax pulse cycle.
   task automatic run_vector(input string name, input bit stall, input bit hold,
                             input logic [31:0] exp_idx, input logic [31:0] exp_val);
      int beat;
      int cyc;
      bus.vec_data  = vec_in;
      bus.vec_valid = 1'b1;
      bus.m_ready   = 1'b0;
      check({name, ":vec_ready_idle"}, bus.vec_ready, 1);
      @(posedge clk);
      @(negedge clk);
      if (hold) bus.vec_data = vec_hold;
      else      bus.vec_valid = 1'b0;
      beat = 0;
      cyc  = 0;
      while (beat < N && cyc < 400) begin
         bus.m_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         check({name, ":m_valid"},  bus.m_valid, 1);
         check({name, ":m_index"},  bus.m_index, beat);
         check({name, ":m_data"},   bus.m_data, exp_out[beat]);
         check({name, ":m_last"},   bus.m_last, (beat == N - 1));
         check({name, ":vec_ready_busy"}, bus.vec_ready, 0);
         check({name, ":argmax_quiet"},   bus.argmax_valid, 0);
         if (bus.m_ready) beat++;
         cyc++;
         @(negedge clk);
      end
      check({name, ":beats"}, beat, N);
      bus.m_ready = 1'b0;
      check({name, ":argmax_valid"}, bus.argmax_valid, 1);
      check({name, ":argmax_idx"},   bus.argmax_idx, exp_idx);
      check({name, ":argmax_val"},   bus.argmax_val, exp_val);
      check({name, ":vec_ready_back"}, bus.vec_ready, 1);
      check({name, ":m_valid_off"},  bus.m_valid, 0);
   endtask

   task automatic idle_check(input string name, input logic [31:0] exp_idx, input logic [31:0] exp_val);
      @(negedge clk);
      check({name, ":pulse_one_cycle"}, bus.argmax_valid, 0);
      check({name, ":idx_hold"}, bus.argmax_idx, exp_idx);
      check({name, ":val_hold"}, bus.argmax_val, exp_val);
   endtask

   task automatic reset_outputs(input string name);
      check({name, ":vec_ready"},    bus.vec_ready, 1);
      check({name, ":m_valid"},      bus.m_valid, 0);
      check({name, ":m_data"},       bus.m_data, 0);
      check({name, ":m_index"},      bus.m_index, 0);
      check({name, ":m_last"},       bus.m_last, 0);
      check({name, ":argmax_valid"}, bus.argmax_valid, 0);
      check({name, ":argmax_idx"},   bus.argmax_idx, 0);
      check({name, ":argmax_val"},   bus.argmax_val, 0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.vec_valid = 1'b0;
      bus.m_ready   = 1'b0;
      for (int i = 0; i < N; i++) bus.vec_data[i] = 16'h0;
      repeat (3) @(negedge clk);
      reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < N; i++) begin vec_in[i] = 16'd125; exp_out[i] = 16'd125; end
      run_vector("flat125", 1'b0, 1'b0, 0, 125);
      idle_check("flat125", 0, 125);

      for (int i = 0; i < N; i++) begin vec_in[i] = 16'(10 * i); exp_out[i] = 16'(10 * i); end
      run_vector("ramp_stall", 1'b1, 1'b0, 14, 140);
      idle_check("ramp_stall", 14, 140);

      for (int i = 0; i < N; i++) vec_in[i] = 16'hFFEC;
      vec_in[3] = 16'hFFF6;
      vec_in[7] = 16'hFF00;
`ifdef LAYER_OUTPUT_RELU_EN
      for (int i = 0; i < N; i++) exp_out[i] = 16'h0000;
      run_vector("negatives", 1'b0, 1'b0, 0, 0);
      idle_check("negatives", 0, 0);
`else
      for (int i = 0; i < N; i++) exp_out[i] = vec_in[i];
      run_vector("negatives", 1'b0, 1'b0, 3, 32'h0000FFF6);
      idle_check("negatives", 3, 32'h0000FFF6);
`endif

      for (int i = 0; i < N; i++) begin
         vec_in[i]   = 16'(200 - 5 * i);
         exp_out[i]  = 16'(200 - 5 * i);
         vec_hold[i] = 16'd7;
      end
      run_vector("hold_first", 1'b0, 1'b1, 0, 200);
      for (int i = 0; i < N; i++) begin vec_in[i] = 16'd7; exp_out[i] = 16'd7; end
      run_vector("hold_second", 1'b0, 1'b0, 0, 7);

      for (int i = 0; i < N; i++) vec_in[i] = 16'(10 * i);
      bus.vec_data  = vec_in;
      bus.vec_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.vec_valid = 1'b0;
      bus.m_ready   = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("midrst:pre_index", bus.m_index, 6);
      rst_n = 1'b0;
      #1;
      reset_outputs("midrst");
      bus.m_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("midrst:no_stream", bus.m_valid, 0);
         check("midrst:no_pulse",  bus.argmax_valid, 0);
      end

      for (int i = 0; i < N; i++) begin vec_in[i] = 16'd42; exp_out[i] = 16'd42; end
      run_vector("after_rst", 1'b0, 1'b0, 0, 42);
      idle_check("after_rst", 0, 42);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
